dino_pixel_gen: RTL

//  Per-pixel compositor feeding the VGA timing block. It takes row_addr/col_addr from the VGA

---
 rtl/dino_pixel_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dino_pixel_gen.sv
// dino_pixel_gen: per-pixel compositor for the VGA timing block.
// Layers a dashed ground line, the dino sprite and an obstacle sprite into one
// monochrome pixel (1 = ink). Game state is shadowed at the frame boundary, and
// dino/obstacle overlap is reported once per frame on the collision output.
`timescale 1ns/1ps
module dino_pixel_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int GROUND_ROW = 400,
  parameter int DINO_X     = 64,
  parameter int X_SKEW     = 2
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [11:0] row_addr,
  input  logic [11:0] col_addr,
  input  logic [11:0] dino_y,
  input  logic [1:0]  dino_frame,
  input  logic [11:0] obst_x,
  input  logic [1:0]  obst_type,
  input  logic        obst_en,
  input  logic [5:0]  ground_ofs,
  input  logic        game_over,
  output logic [6:0]  dino_rom_addr,
  input  logic [31:0] dino_rom_data,
  output logic [6:0]  obst_rom_addr,
  input  logic [31:0] obst_rom_data,
  output logic        pixel,
  output logic        frame_tick,
  output logic        collision
);

  localparam logic [11:0] OBST_TOP = 12'(GROUND_ROW - 32);

  // frame-stable copies of the game inputs
  logic [11:0] sh_dino_y;
  logic [1:0]  sh_frame;
  logic [11:0] sh_obst_x;
  logic [1:0]  sh_obst_type;
  logic        sh_obst_en;
  logic [5:0]  sh_ground_ofs;
  logic        sh_game_over;
  logic        acc;

  // stage S0 registers
  logic        vis_q;
  logic        hit_d_q;
  logic        hit_o_q;
  logic [4:0]  dc_q;
  logic [4:0]  oc_q;
  logic        g_q;

  logic [11:0] col_s;
  logic [11:0] dr;
  logic [11:0] dc;
  logic [11:0] orow;
  logic [11:0] oc;
  logic [5:0]  gsum;
  logic        boundary;
  logic        vis_c;
  logic        hit_d_c;
  logic        hit_o_c;
  logic        g_c;
  logic        d_bit;
  logic        o_bit;

  // all sprite-relative coordinates wrap at 12 bits, so negative offsets land far out of range
  assign col_s    = col_addr + 12'(X_SKEW);
  assign dr       = row_addr - sh_dino_y;
  assign dc       = col_s - 12'(DINO_X);
  assign orow     = row_addr - OBST_TOP;
  assign oc       = col_s - sh_obst_x;
  assign gsum     = col_s[5:0] + sh_ground_ofs;
  assign boundary = (row_addr == 12'(V_ACTIVE)) && (col_addr == 12'd0);
  assign vis_c    = (row_addr < 12'(V_ACTIVE)) && (col_s < 12'(H_ACTIVE));
  assign hit_d_c  = (dr < 12'd32) && (dc < 12'd32);
  assign hit_o_c  = sh_obst_en && (orow < 12'd32) && (oc < 12'd32);
  assign g_c      = (row_addr == 12'(GROUND_ROW)) ? (gsum < 6'd48)
                                                  : (row_addr == 12'(GROUND_ROW + 1));

  // ROM addresses feed the ROM's own input register, which forms the S0 stage for sprite data
  assign dino_rom_addr = rst ? 7'd0 : {sh_frame, dr[4:0]};
  assign obst_rom_addr = rst ? 7'd0 : {sh_obst_type, orow[4:0]};

  // ROM data arrives alongside the S0 registers; bit 31 is the leftmost sprite pixel
  assign d_bit = hit_d_q & dino_rom_data[5'd31 - dc_q];
  assign o_bit = hit_o_q & obst_rom_data[5'd31 - oc_q];

  // shadow game state, frame tick and per-frame collision accumulation
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      sh_dino_y     <= OBST_TOP;
      sh_frame      <= 2'd0;
      sh_obst_x     <= 12'd0;
      sh_obst_type  <= 2'd0;
      sh_obst_en    <= 1'b0;
      sh_ground_ofs <= 6'd0;
      sh_game_over  <= 1'b0;
      frame_tick    <= 1'b0;
      collision     <= 1'b0;
      acc           <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (boundary) begin
        sh_dino_y     <= dino_y;
        sh_frame      <= dino_frame;
        sh_obst_x     <= obst_x;
        sh_obst_type  <= obst_type;
        sh_obst_en    <= obst_en;
        sh_ground_ofs <= ground_ofs;
        sh_game_over  <= game_over;
        collision     <= acc;
        acc           <= 1'b0;
      end else begin
        acc <= acc | (vis_q & d_bit & o_bit);
      end
    end
  end

  // S0: visibility, sprite hit tests and ground flag
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      vis_q   <= 1'b0;
      hit_d_q <= 1'b0;
      hit_o_q <= 1'b0;
      dc_q    <= 5'd0;
      oc_q    <= 5'd0;
      g_q     <= 1'b0;
    end else begin
      vis_q   <= vis_c;
      hit_d_q <= hit_d_c;
      hit_o_q <= hit_o_c;
      dc_q    <= dc[4:0];
      oc_q    <= oc[4:0];
      g_q     <= g_c;
    end
  end

  // S1: composite the layers; game_over inverts only the visible area
  always_ff @(posedge vga_clk) begin
    if (rst) pixel <= 1'b0;
    else     pixel <= vis_q & ((d_bit | o_bit | g_q) ^ sh_game_over);
  end

endmodule
